// File: rtl/hcsr04_responder.sv
// HC-SR04 ultrasonic sensor emulator: answers a trigger pulse with an echo pulse
// whose width encodes a simulated target distance, then holds off before re-arming.
module hcsr04_responder #(
    parameter int unsigned CYCLES_PER_CM  = 2941,
    parameter int unsigned TRIG_MIN       = 500,
    parameter int unsigned BURST_DELAY    = 25000,
    parameter int unsigned TIMEOUT_CYCLES = 1900000,
    parameter int unsigned HOLDOFF        = 500000
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       trigger,
    input  logic [8:0] distancia,
    output logic       echo,
    output logic       ocupado,
    output logic       pronto,
    output logic [2:0] db_estado
);

    localparam int unsigned CW       = 22;
    localparam int unsigned DW       = 9;
    localparam int unsigned DIST_MIN = 2;
    localparam int unsigned DIST_MAX = 400;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_TRIG  = 3'd1,
        S_BURST = 3'd2,
        S_ECHO  = 3'd3,
        S_HOLD  = 3'd4
    } state_t;

    state_t          state;
    state_t          next_state;
    logic [1:0]      sync_q;
    logic            trig_s;
    logic            armed_q;
    logic [CW-1:0]   cnt_q;
    logic [DW-1:0]   dist_q;
    logic [CW-1:0]   width_c;
    logic            echo_c;
    logic            ocupado_c;
    logic            pronto_c;

    assign trig_s    = sync_q[1];
    assign db_estado = state;

    // Echo width from the latched distance; out-of-range targets report a timeout.
    always_comb begin
        width_c = CW'(TIMEOUT_CYCLES);
        if (dist_q >= DW'(DIST_MIN) && dist_q <= DW'(DIST_MAX))
            width_c = CW'(dist_q) * CW'(CYCLES_PER_CM);
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) state <= S_IDLE;
        else        state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            S_IDLE:  if (armed_q && trig_s) next_state = S_TRIG;
            S_TRIG:  if (!trig_s)
                         next_state = (cnt_q >= CW'(TRIG_MIN)) ? S_BURST : S_IDLE;
            S_BURST: if (cnt_q == CW'(BURST_DELAY - 1)) next_state = S_ECHO;
            S_ECHO:  if (cnt_q == width_c - CW'(1))     next_state = S_HOLD;
            S_HOLD:  if (cnt_q == CW'(HOLDOFF - 1))     next_state = S_IDLE;
            default: next_state = S_IDLE;
        endcase
    end

    // Output values for the next cycle; registered below.
    always_comb begin
        echo_c    = 1'b0;
        ocupado_c = 1'b0;
        pronto_c  = 1'b0;
        echo_c    = (next_state == S_ECHO);
        ocupado_c = (next_state != S_IDLE);
        pronto_c  = (state == S_ECHO) && (next_state == S_HOLD);
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            sync_q  <= '0;
            armed_q <= 1'b0;
            cnt_q   <= '0;
            dist_q  <= '0;
            echo    <= 1'b0;
            ocupado <= 1'b0;
            pronto  <= 1'b0;
        end else begin
            sync_q  <= {sync_q[0], trigger};
            // IDLE only accepts a rise after it has seen trig_s low at least once.
            armed_q <= (state == S_IDLE) && (armed_q || !trig_s);
            if (state != next_state)
                cnt_q <= (next_state == S_TRIG) ? CW'(1) : '0;
            else if (state != S_IDLE && cnt_q != {CW{1'b1}})
                cnt_q <= cnt_q + CW'(1);
            if (state == S_TRIG && next_state == S_BURST)
                dist_q <= distancia;
            echo    <= echo_c;
            ocupado <= ocupado_c;
            pronto  <= pronto_c;
        end
    end

endmodule

// File: tb/tb_hcsr04_responder.sv
// Randomized self-checking bench for hcsr04_responder against a timeline model
// derived from distance, trigger width and the timing parameters.
module tb_hcsr04_responder;

    localparam int CPC  = 4;
    localparam int TMIN = 5;
    localparam int BD   = 10;
    localparam int TO   = 2000;
    localparam int HO   = 50;
    // Samples after trigger falls: two synchronizer flops, one cycle to act on the fall, then the burst.
    localparam int RISE_IDX = 2 + 1 + BD;

    logic       clock = 1'b0;
    logic       reset;
    logic       trigger;
    logic [8:0] distancia;
    logic       echo;
    logic       ocupado;
    logic       pronto;
    logic [2:0] db_estado;

    int checks = 0;
    int passed = 0;

    int m_rise, m_width, m_pulses, m_pronto, m_pronto_idx, m_idle_idx, m_bad;
    int st_hist[$];

    hcsr04_responder #(
        .CYCLES_PER_CM(CPC), .TRIG_MIN(TMIN), .BURST_DELAY(BD),
        .TIMEOUT_CYCLES(TO), .HOLDOFF(HO)
    ) dut (
        .clock(clock), .reset(reset), .trigger(trigger), .distancia(distancia),
        .echo(echo), .ocupado(ocupado), .pronto(pronto), .db_estado(db_estado)
    );

    always #5 clock = ~clock;

    initial begin
        #900us;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    function automatic int model_width(input int d);
        return (d >= 2 && d <= 400) ? d * CPC : TO;
    endfunction

    task automatic pulse_trigger(input int n);
        @(negedge clock);
        trigger = 1'b1;
        repeat (n) @(negedge clock);
        trigger = 1'b0;
    endtask

    task automatic wait_idle();
        int done = 0;
        for (int i = 0; i < 5000; i++) begin
            @(negedge clock);
            if (ocupado === 1'b0) begin done = 1; break; end
        end
        checks++;
        if (done != 1) $display("FAIL wait_idle: ocupado still %b after 5000 cycles", ocupado);
        else passed++;
        repeat (3) @(negedge clock);
    endtask

    // Sample once per cycle from the trigger fall; optionally drive trigger high
    // for rt_len cycles from sample rt_at and switch distancia to new_d there.
    task automatic observe(input int budget, input int rt_at, input int rt_len, input int new_d);
        logic prev_echo = 1'b0;
        m_rise = -1; m_width = 0; m_pulses = 0; m_pronto = 0;
        m_pronto_idx = -1; m_idle_idx = -1; m_bad = 0;
        st_hist.delete();
        st_hist.push_back(int'(db_estado));
        for (int i = 1; i <= budget; i++) begin
            @(negedge clock);
            st_hist.push_back(int'(db_estado));
            if (echo === 1'b1) begin
                m_width++;
                if (prev_echo !== 1'b1) begin
                    m_pulses++;
                    if (m_rise < 0) m_rise = i;
                end
            end
            if (pronto === 1'b1) begin
                m_pronto++;
                if (m_pronto_idx < 0) m_pronto_idx = i;
            end
            if (echo !== (db_estado == 3'd3) || ocupado !== (db_estado != 3'd0)) m_bad++;
            if (m_rise >= 0 && ocupado === 1'b0 && m_idle_idx < 0) m_idle_idx = i;
            prev_echo = echo;
            if (i == rt_at) begin trigger = 1'b1; distancia = 9'(new_d); end
            if (i == rt_at + rt_len) trigger = 1'b0;
            if (m_idle_idx >= 0 && i >= m_idle_idx + 30) break;
        end
    endtask

    task automatic test_reset();
        reset = 1'b0; trigger = 1'b0; distancia = '0;
        repeat (3) @(negedge clock);
        checks++; if ({echo, ocupado, pronto} !== 3'b000) $display("FAIL reset_outputs: got %b expected 000", {echo, ocupado, pronto}); else passed++;
        checks++; if (db_estado !== 3'd0) $display("FAIL reset_state: got %0d expected 0", db_estado); else passed++;
        reset = 1'b1;
        repeat (3) @(negedge clock);
        checks++; if (db_estado !== 3'd0) $display("FAIL idle_after_reset: got %0d expected 0", db_estado); else passed++;
    endtask

    task automatic test_nominal();
        int w = model_width(100);
        wait_idle();
        distancia = 9'd100;
        pulse_trigger(8);
        observe(3000, -1, 0, 0);
        checks++; if (m_rise !== RISE_IDX) $display("FAIL nom_rise: got %0d expected %0d", m_rise, RISE_IDX); else passed++;
        checks++; if (m_width !== w) $display("FAIL nom_width: got %0d expected %0d", m_width, w); else passed++;
        checks++; if (m_pronto !== 1 || m_pronto_idx !== RISE_IDX + w) $display("FAIL nom_pronto: got %0d pulses at %0d expected 1 at %0d", m_pronto, m_pronto_idx, RISE_IDX + w); else passed++;
        checks++; if (m_idle_idx !== RISE_IDX + w + HO) $display("FAIL nom_ocupado_fall: got %0d expected %0d", m_idle_idx, RISE_IDX + w + HO); else passed++;
        checks++; if (st_hist[2] !== 1 || st_hist[3] !== 2 || st_hist[RISE_IDX - 1] !== 2) $display("FAIL nom_trig_burst_states: got %0d %0d %0d expected 1 2 2", st_hist[2], st_hist[3], st_hist[RISE_IDX - 1]); else passed++;
        checks++; if (st_hist[RISE_IDX] !== 3 || st_hist[RISE_IDX + w] !== 4 || st_hist[RISE_IDX + w + HO] !== 0) $display("FAIL nom_echo_hold_states: got %0d %0d %0d expected 3 4 0", st_hist[RISE_IDX], st_hist[RISE_IDX + w], st_hist[RISE_IDX + w + HO]); else passed++;
        checks++; if (m_bad !== 0) $display("FAIL nom_invariants: got %0d violations expected 0", m_bad); else passed++;
    endtask

    task automatic test_short_trigger();
        for (int k = 0; k < 4; k++) begin
            int len = (k == 0) ? 3 : (k == 1) ? TMIN - 1 : int'($urandom_range(1, TMIN - 1));
            wait_idle();
            distancia = 9'(100);
            pulse_trigger(len);
            observe(80, -1, 0, 0);
            checks++; if (m_pulses !== 0 || m_pronto !== 0) $display("FAIL short_len%0d: got %0d echo %0d pronto expected 0 0", len, m_pulses, m_pronto); else passed++;
            checks++; if (st_hist[3] !== 0) $display("FAIL short_idle_len%0d: got state %0d expected 0", len, st_hist[3]); else passed++;
        end
    endtask

    task automatic test_range();
        int dl[$] = '{1, 0, 401, 511, 2, 400};
        for (int k = 0; k < 6; k++) dl.push_back(int'($urandom_range(0, 511)));
        foreach (dl[k]) begin
            int d   = dl[k];
            int w   = model_width(d);
            int len = (k == 4) ? TMIN : int'($urandom_range(TMIN, TMIN + 6));
            wait_idle();
            distancia = 9'(d);
            pulse_trigger(len);
            observe(2500, -1, 0, 0);
            checks++; if (m_rise !== RISE_IDX) $display("FAIL range_rise d=%0d: got %0d expected %0d", d, m_rise, RISE_IDX); else passed++;
            checks++; if (m_width !== w || m_pulses !== 1) $display("FAIL range_width d=%0d: got %0d in %0d pulses expected %0d in 1", d, m_width, m_pulses, w); else passed++;
            checks++; if (m_pronto !== 1 || m_pronto_idx !== RISE_IDX + w) $display("FAIL range_pronto d=%0d: got %0d at %0d expected 1 at %0d", d, m_pronto, m_pronto_idx, RISE_IDX + w); else passed++;
        end
    endtask

    task automatic test_retrigger_latch();
        wait_idle();
        distancia = 9'd100;
        pulse_trigger(8);
        observe(3000, RISE_IDX + 30, 20, 50);
        checks++; if (m_width !== model_width(100) || m_pulses !== 1) $display("FAIL retrig_width: got %0d in %0d pulses expected %0d in 1", m_width, m_pulses, model_width(100)); else passed++;
        checks++; if (m_pronto !== 1) $display("FAIL retrig_pronto: got %0d expected 1", m_pronto); else passed++;
    endtask

    task automatic test_hold_overlap();
        int w = model_width(2);
        wait_idle();
        distancia = 9'd2;
        pulse_trigger(8);
        observe(400, RISE_IDX + w + 10, 1000, 2);
        checks++; if (m_pulses !== 1 || m_width !== w) $display("FAIL hold_overlap_echo: got %0d pulses width %0d expected 1 width %0d", m_pulses, m_width, w); else passed++;
        checks++; if (db_estado !== 3'd0 || trigger !== 1'b1) $display("FAIL hold_overlap_idle: got state %0d trigger %b expected 0 1", db_estado, trigger); else passed++;
        trigger = 1'b0;
    endtask

    task automatic test_held_trigger();
        int d = int'($urandom_range(2, 400));
        int w = model_width(d);
        int bad = 0;
        wait_idle();
        distancia = 9'(d);
        @(negedge clock);
        trigger = 1'b1;
        for (int i = 0; i < 3000; i++) begin
            @(negedge clock);
            if (echo !== 1'b0) bad++;
        end
        checks++; if (bad !== 0) $display("FAIL held_no_echo: got %0d echo-high samples expected 0", bad); else passed++;
        checks++; if (db_estado !== 3'd1) $display("FAIL held_state: got %0d expected 1", db_estado); else passed++;
        trigger = 1'b0;
        observe(2500, -1, 0, 0);
        checks++; if (m_rise !== RISE_IDX || m_width !== w) $display("FAIL held_echo d=%0d: got rise %0d width %0d expected %0d %0d", d, m_rise, m_width, RISE_IDX, w); else passed++;
    endtask

    task automatic test_reset_mid_echo();
        int pr = 0;
        wait_idle();
        distancia = 9'd100;
        pulse_trigger(8);
        repeat (RISE_IDX + 200) @(negedge clock);
        checks++; if (echo !== 1'b1) $display("FAIL mid_echo_before_reset: got %b expected 1", echo); else passed++;
        #2 reset = 1'b0;
        #1;
        checks++; if ({echo, ocupado} !== 2'b00 || db_estado !== 3'd0) $display("FAIL mid_echo_async_reset: got echo %b ocupado %b state %0d expected 0 0 0", echo, ocupado, db_estado); else passed++;
        for (int i = 0; i < 5; i++) begin
            @(negedge clock);
            if (pronto !== 1'b0) pr++;
        end
        reset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clock);
            if (pronto !== 1'b0) pr++;
        end
        checks++; if (pr !== 0) $display("FAIL mid_echo_no_pronto: got %0d pronto samples expected 0", pr); else passed++;
        pulse_trigger(8);
        observe(3000, -1, 0, 0);
        checks++; if (m_rise !== RISE_IDX || m_width !== 400 || m_pronto !== 1) $display("FAIL after_reset_echo: got rise %0d width %0d pronto %0d expected %0d 400 1", m_rise, m_width, m_pronto, RISE_IDX); else passed++;
    endtask

    initial begin
        test_reset();
        test_nominal();
        test_short_trigger();
        test_range();
        test_retrigger_latch();
        test_hold_overlap();
        test_held_trigger();
        test_reset_mid_echo();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
